// File: rtl/sobel_pkg.sv
// Shared types, widths and kernel coefficients for the Sobel edge stage.
// Helper functions keep the gradient arithmetic identical across users.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int GRAD_W  = 11;
  localparam int MAG_MAX = 255;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic [GRAD_W-1:0]        ugrad_t;
  typedef logic signed [GRAD_W-1:0] grad_t;

  localparam ugrad_t K_SIDE = 11'd1;
  localparam ugrad_t K_MID  = 11'd2;

  // weighted 1-2-1 sum of three taps
  function automatic ugrad_t tap3(
    input pix_t a,
    input pix_t b,
    input pix_t c
  );
    return K_SIDE * ugrad_t'(a)
         + K_MID  * ugrad_t'(b)
         + K_SIDE * ugrad_t'(c);
  endfunction

  function automatic ugrad_t abs_g(input grad_t v);
    return v[GRAD_W-1] ? ugrad_t'(-v) : ugrad_t'(v);
  endfunction

  function automatic pix_t sat_mag(input ugrad_t s);
    return (s > ugrad_t'(MAG_MAX)) ? pix_t'(MAG_MAX)
                                   : s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_window_if.sv
// Pixel stream bundle into and out of the Sobel stage.
// master drives pixels in, slave is the Sobel block.
interface sobel_window_if;
  import sobel_pkg::*;

  logic pix_valid;
  logic frame_start;
  pix_t gray_in;
  pix_t threshold;
  logic out_valid;
  logic out_frame_start;
  pix_t mag_out;
  logic edge_out;

  modport master (
    output pix_valid,
    output frame_start,
    output gray_in,
    output threshold,
    input  out_valid,
    input  out_frame_start,
    input  mag_out,
    input  edge_out
  );

  modport slave (
    input  pix_valid,
    input  frame_start,
    input  gray_in,
    input  threshold,
    output out_valid,
    output out_frame_start,
    output mag_out,
    output edge_out
  );

endinterface

// File: rtl/sobel_window_line_buffer.sv
// One-line pixel store: one write port, one registered read port.
// A same-address read returns the old contents (read-before-write).
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // write and registered read share the clock edge
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sobel_window.sv
// 3x3 Sobel window on a gray pixel stream, fixed 4-cycle latency.
// Outputs saturated |Gx|+|Gy| and a thresholded edge bit.
module sobel_window #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9
) (
  input logic        clock,
  input logic        reset,
  sobel_window_if.slave bus
);
  import sobel_pkg::*;

  logic [COL_W-1:0] col_cnt;
  logic [COL_W-1:0] pos_col;
  logic [COL_W-1:0] nxt_col;
  logic [COL_W-1:0] col0;
  logic [ROW_W-1:0] row_cnt;
  logic [ROW_W-1:0] pos_row;
  logic [ROW_W-1:0] nxt_row;
  logic             col_last;
  logic             row_last;
  logic             border_in;
  logic             lb0_we;

  logic v0, v1, v2;
  logic fs0, fs1, fs2;
  logic b0, b1, b2;

  pix_t gray0;
  pix_t lb0_q;
  pix_t lb1_q;
  pix_t win [3][3];

  grad_t  gx_d, gy_d;
  grad_t  gx2, gy2;
  ugrad_t sum3;
  pix_t   mag3;

  logic valid_q;
  logic ofs_q;
  pix_t mag_q;
  logic edge_q;

  // position of the incoming pixel, with frame_start resync
  always_comb begin
    pos_col   = bus.frame_start ? '0 : col_cnt;
    pos_row   = bus.frame_start ? '0 : row_cnt;
    col_last  = pos_col == COL_W'(H_ACTIVE - 1);
    row_last  = pos_row == ROW_W'(V_ACTIVE - 1);
    nxt_col   = col_last ? '0 : pos_col + COL_W'(1);
    nxt_row   = pos_row;
    if (col_last)
      nxt_row = row_last ? '0 : pos_row + ROW_W'(1);
    border_in = (pos_row < ROW_W'(2))
             || (pos_col < COL_W'(2));
    lb0_we    = bus.pix_valid && !reset;
  end

  // row/col counters advance only on accepted pixels
  always_ff @(posedge clock) begin
    if (reset) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (bus.pix_valid) begin
      col_cnt <= nxt_col;
      row_cnt <= nxt_row;
    end
  end

  line_buffer #(
    .DEPTH(H_ACTIVE), .AW(COL_W), .DW(PIX_W)
  ) u_lb0 (
    .clock(clock),
    .we   (lb0_we),
    .waddr(pos_col),
    .wdata(bus.gray_in),
    .raddr(pos_col),
    .rdata(lb0_q)
  );

  // lb1 takes the row lb0 just gave up, one cycle later
  line_buffer #(
    .DEPTH(H_ACTIVE), .AW(COL_W), .DW(PIX_W)
  ) u_lb1 (
    .clock(clock),
    .we   (v0),
    .waddr(col0),
    .wdata(lb0_q),
    .raddr(pos_col),
    .rdata(lb1_q)
  );

  // valid, frame-start and border flags ride with the pixel
  always_ff @(posedge clock) begin
    if (reset) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      fs0     <= 1'b0;
      fs1     <= 1'b0;
      fs2     <= 1'b0;
      b0      <= 1'b0;
      b1      <= 1'b0;
      b2      <= 1'b0;
      valid_q <= 1'b0;
      ofs_q   <= 1'b0;
      mag_q   <= '0;
      edge_q  <= 1'b0;
    end else begin
      v0      <= bus.pix_valid;
      fs0     <= bus.pix_valid && bus.frame_start;
      b0      <= border_in;
      v1      <= v0;
      fs1     <= fs0;
      b1      <= b0;
      v2      <= v1;
      fs2     <= fs1;
      b2      <= b1;
      valid_q <= v2;
      ofs_q   <= v2 && fs2;
      mag_q   <= (v2 && !b2) ? mag3 : '0;
      edge_q  <= v2 && !b2
              && (mag3 >= bus.threshold);
    end
  end

  // window shifts left on each valid pixel, holds on bubbles
  always_ff @(posedge clock) begin
    gray0 <= bus.gray_in;
    col0  <= pos_col;
    if (v0) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_q;
      win[1][2] <= lb0_q;
      win[2][2] <= gray0;
    end
  end

  // horizontal and vertical gradients of the current window
  always_comb begin
    gx_d = $signed(
      tap3(win[0][2], win[1][2], win[2][2])
    - tap3(win[0][0], win[1][0], win[2][0]));
    gy_d = $signed(
      tap3(win[2][0], win[2][1], win[2][2])
    - tap3(win[0][0], win[0][1], win[0][2]));
  end

  // gradient register stage
  always_ff @(posedge clock) begin
    gx2 <= gx_d;
    gy2 <= gy_d;
  end

  // L1 magnitude with saturation
  always_comb begin
    sum3 = abs_g(gx2) + abs_g(gy2);
    mag3 = sat_mag(sum3);
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_frame_start = ofs_q;
  assign bus.mag_out         = mag_q;
  assign bus.edge_out        = edge_q;

endmodule

// File: tb/tb_sobel_window.sv
// Scoreboard bench for sobel_window on an 8x6 frame.
// Expected pixels come from a frame-image Sobel model.
module tb_sobel_window;

  localparam int H = 8;
  localparam int V = 6;

  typedef struct {
    int         due;
    logic       fs;
    logic [7:0] mag;
    logic       edge_v;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  int   nout   = 0;
  int   mr     = 0;
  int   mc     = 0;

  logic [7:0] img [V][H];
  exp_t       q[$];

  sobel_window_if bus ();

  sobel_window #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .COL_W   (3),
    .ROW_W   (3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic exp_t model(
    input int   r,
    input int   c,
    input logic fs
  );
    exp_t e;
    int   gx, gy, s;
    int   p [3][3];
    e.due    = 0;
    e.fs     = fs;
    e.mag    = 8'd0;
    e.edge_v = 1'b0;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          p[i][j] = int'(img[r-2+i][c-2+j]);
      gx = (p[0][2] + 2*p[1][2] + p[2][2])
         - (p[0][0] + 2*p[1][0] + p[2][0]);
      gy = (p[2][0] + 2*p[2][1] + p[2][2])
         - (p[0][0] + 2*p[0][1] + p[0][2]);
      s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (s > 255) s = 255;
      e.mag    = 8'(s);
      e.edge_v = (e.mag >= bus.threshold);
    end
    return e;
  endfunction

  function automatic logic [7:0] pix_val(
    input int kind,
    input int c
  );
    case (kind)
      0:       return 8'd100;
      1:       return (c < 4) ? 8'd0 : 8'd255;
      default: return 8'(20 * c);
    endcase
  endfunction

  task automatic drive_pix(
    input logic [7:0] g,
    input logic       fs
  );
    exp_t e;
    @(negedge clock);
    bus.pix_valid   = 1'b1;
    bus.frame_start = fs;
    bus.gray_in     = g;
    if (fs) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = g;
    e     = model(mr, mc, fs);
    e.due = cyc + 4;
    q.push_back(e);
    if (mc == H - 1) begin
      mc = 0;
      mr = (mr == V - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic send_frame(
    input int   kind,
    input logic first_fs
  );
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        drive_pix(pix_val(kind, c),
                  (r == 0 && c == 0) ? first_fs : 1'b0);
  endtask

  task automatic drain();
    @(negedge clock);
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(negedge clock);
    repeat (2) @(negedge clock);
  endtask

  // scoreboard: every out_valid pops one expected pixel
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_out due=%0d now=%0d",
               q[0].due, cyc);
      void'(q.pop_front());
    end
    if (bus.out_valid === 1'b1) begin
      nout++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out cyc=%0d mag=%0d",
                 cyc, bus.mag_out);
      end else begin
        e = q.pop_front();
        checks += 4;
        if (cyc !== e.due) begin
          errors++;
          $display("FAIL latency got=%0d want=%0d",
                   cyc, e.due);
        end
        if (bus.mag_out !== e.mag) begin
          errors++;
          $display("FAIL mag_out got=%0d want=%0d cyc=%0d",
                   bus.mag_out, e.mag, cyc);
        end
        if (bus.edge_out !== e.edge_v) begin
          errors++;
          $display("FAIL edge_out got=%0b want=%0b cyc=%0d",
                   bus.edge_out, e.edge_v, cyc);
        end
        if (bus.out_frame_start !== e.fs) begin
          errors++;
          $display("FAIL out_frame_start got=%0b want=%0b",
                   bus.out_frame_start, e.fs);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b want=0",
               bus.out_valid);
    end
    if (bus.mag_out !== 8'd0) begin
      errors++;
      $display("FAIL reset_mag got=%0d want=0",
               bus.mag_out);
    end
    if (bus.edge_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_edge got=%b want=0",
               bus.edge_out);
    end
    if (bus.out_frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_fs got=%b want=0",
               bus.out_frame_start);
    end
    @(negedge clock);
    reset = 1'b0;
    mr    = 0;
    mc    = 0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_flat();
    int n0;
    n0 = nout;
    bus.threshold = 8'd128;
    send_frame(0, 1'b1);
    drain();
    checks += 2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL flat_drain left=%0d want=0", q.size());
    end
    if (nout - n0 != H * V) begin
      errors++;
      $display("FAIL flat_count got=%0d want=%0d",
               nout - n0, H * V);
    end
  endtask

  task automatic test_step();
    bus.threshold = 8'd128;
    send_frame(1, 1'b1);
    drain();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL step_drain left=%0d want=0", q.size());
    end
  endtask

  task automatic test_ramp();
    logic [7:0] th [3];
    th[0] = 8'd128;
    th[1] = 8'd80;
    th[2] = 8'd200;
    for (int k = 0; k < 3; k++) begin
      bus.threshold = th[k];
      send_frame(2, 1'b1);
      drain();
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL ramp_drain th=%0d left=%0d want=0",
                 th[k], q.size());
      end
    end
    bus.threshold = 8'd128;
  endtask

  task automatic test_border_latency();
    int n0;
    n0 = nout;
    for (int i = 0; i < H * V; i++) begin
      drive_pix(8'($urandom_range(0, 255)), i == 0);
      repeat (i % 4) begin
        @(negedge clock);
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
      end
    end
    drain();
    checks += 2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pulse_drain left=%0d want=0", q.size());
    end
    if (nout - n0 != H * V) begin
      errors++;
      $display("FAIL pulse_count got=%0d want=%0d",
               nout - n0, H * V);
    end
  endtask

  task automatic test_resync();
    int n0;
    n0 = nout;
    for (int i = 0; i < 29; i++)
      drive_pix(8'($urandom_range(0, 255)), i == 0);
    drive_pix(8'd255, 1'b1);
    for (int i = 0; i < 3 * H; i++)
      drive_pix(8'($urandom_range(0, 255)), 1'b0);
    drain();
    checks += 2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL resync_drain left=%0d want=0", q.size());
    end
    if (nout - n0 != 30 + 3 * H) begin
      errors++;
      $display("FAIL resync_count got=%0d want=%0d",
               nout - n0, 30 + 3 * H);
    end
  endtask

  task automatic test_reset_mid();
    bus.threshold = 8'd128;
    for (int i = 0; i < 3 * H + 3; i++)
      drive_pix(pix_val(1, i % H), i == 0);
    @(negedge clock);
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    reset           = 1'b1;
    q.delete();
    @(posedge clock);
    #1;
    checks += 3;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_valid got=%b want=0",
               bus.out_valid);
    end
    if (bus.mag_out !== 8'd0) begin
      errors++;
      $display("FAIL midrst_mag got=%0d want=0",
               bus.mag_out);
    end
    if (bus.edge_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_edge got=%b want=0",
               bus.edge_out);
    end
    @(negedge clock);
    reset = 1'b0;
    mr    = 0;
    mc    = 0;
    repeat (6) @(negedge clock);
    send_frame(1, 1'b0);
    drain();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL midrst_drain left=%0d want=0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.gray_in     = 8'd0;
    bus.threshold   = 8'd128;
    test_reset();
    test_flat();
    test_step();
    test_ramp();
    test_border_latency();
    test_resync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
